// File: rtl/pixel_loader.sv
// Unpacks received bytes into a 1-bit-wide image RAM, LSB first, with a
// one-byte pending buffer. The consumer's release pulse is the port
// img_release because "release" is a reserved word.
module pixel_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_rdy,
  input  logic [7:0]            rx_data,
  input  logic                  img_release,
  input  logic                  clr_err,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_data,
  output logic                  img_done,
  output logic                  loading,
  output logic                  ovr_err
);

  localparam int NUM_BYTES = NUM_PIXELS / 8;
  localparam int BCW       = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {IDLE, UNPACK, WAIT_BYTE, HOLD} state_t;

  state_t                state, next_state;
  logic [BCW-1:0]        byte_cnt;
  logic [2:0]            bit_idx;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [7:0]            cur_byte;
  logic [7:0]            pend_byte;
  logic                  pend_v;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_data_q;
  logic                  img_done_q;
  logic                  loading_q;
  logic                  ovr_err_q;

  logic byte_room, can_take, accept, drop;
  logic byte_end, last_pix, image_end;

  assign byte_room = (byte_cnt < BCW'(NUM_BYTES));
  assign can_take  = (state == IDLE) || (state == WAIT_BYTE) ||
                     ((state == UNPACK) && !pend_v);
  assign accept    = rx_rdy && byte_room && can_take;
  assign drop      = rx_rdy && !accept;
  assign byte_end  = (state == UNPACK) && (bit_idx == 3'd7);
  assign last_pix  = (pix_cnt == ADDR_WIDTH'(NUM_PIXELS - 1));
  assign image_end = byte_end && last_pix;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers sample
    // pre-edge values, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    next_state = state;
    unique case (state)
      IDLE, WAIT_BYTE: if (accept) next_state = UNPACK;
      UNPACK: begin
        if (byte_end) begin
          if (last_pix)               next_state = HOLD;
          else if (pend_v || accept)  next_state = UNPACK;
          else                        next_state = WAIT_BYTE;
        end
      end
      HOLD: if (img_release) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: writes come straight from the unpack position; the address and
  // data lines keep the last written values whenever no write is in progress.
  always_comb begin
    ram_we   = (state == UNPACK);
    ram_addr = ram_addr_q;
    ram_data = ram_data_q;
    if (state == UNPACK) begin
      ram_addr = pix_cnt;
      ram_data = cur_byte[bit_idx];
    end
    img_done = img_done_q;
    loading  = loading_q;
    ovr_err  = ovr_err_q;
  end

  // Datapath: counters, byte buffers and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      bit_idx    <= '0;
      pix_cnt    <= '0;
      cur_byte   <= '0;
      pend_byte  <= '0;
      pend_v     <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= 1'b0;
      img_done_q <= 1'b0;
      loading_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      if (accept) byte_cnt <= byte_cnt + BCW'(1);

      unique case (state)
        IDLE, WAIT_BYTE: begin
          if (accept) begin
            cur_byte  <= rx_data;
            bit_idx   <= '0;
            loading_q <= 1'b1;
          end
        end
        UNPACK: begin
          ram_addr_q <= pix_cnt;
          ram_data_q <= cur_byte[bit_idx];
          bit_idx    <= bit_idx + 3'd1;
          if (!last_pix) pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
          if (byte_end) begin
            if (last_pix) begin
              loading_q <= 1'b0;
            end else if (pend_v) begin
              cur_byte <= pend_byte;
              pend_v   <= 1'b0;
            end else if (accept) begin
              // A byte arriving on the final bit goes straight into the
              // shifter so the writes continue without a gap.
              cur_byte <= rx_data;
            end
          end else if (accept) begin
            pend_byte <= rx_data;
            pend_v    <= 1'b1;
          end
        end
        HOLD: begin
          if (img_release) begin
            byte_cnt <= '0;
            pix_cnt  <= '0;
            bit_idx  <= '0;
            pend_v   <= 1'b0;
          end
        end
        default: ;
      endcase

      img_done_q <= image_end;
      ovr_err_q  <= drop || (ovr_err_q && !clr_err);
    end
  end

endmodule

// File: tb/tb_pixel_loader.sv
// Self-checking bench for pixel_loader: a queue-based model of the pixel
// stream (at most two bytes buffered) predicts every output each cycle.
module tb_pixel_loader;

  localparam int NP = 784;
  localparam int AW = 10;
  localparam int NB = NP / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          img_release = 1'b0;
  logic          clr_err = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          ram_data;
  logic          img_done;
  logic          loading;
  logic          ovr_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wcount[NP];

  pixel_loader #(.NUM_PIXELS(NP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .img_release(img_release), .clr_err(clr_err), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data), .img_done(img_done),
    .loading(loading), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  // Reference model: pixels still to be written, in write order.
  logic    m_bits[$];
  int      m_pix, m_bytes;
  bit      m_hold, m_load, m_err, m_done;
  logic [AW-1:0] m_addr;
  logic    m_data;

  function automatic void model_reset();
    m_bits.delete();
    m_pix = 0; m_bytes = 0; m_hold = 0; m_load = 0; m_err = 0; m_done = 0;
    m_addr = '0; m_data = 1'b0;
  endfunction

  function automatic void model_step(logic rx, logic [7:0] d, logic rel, logic clr);
    int  buffered = (m_bits.size() + 7) / 8;
    bit  was_hold = m_hold;
    bit  acc = rx && (m_bytes < NB) && (buffered < 2) && !m_hold;
    bit  new_done = 0;
    if (m_bits.size() > 0) begin
      m_addr = AW'(m_pix);
      m_data = m_bits.pop_front();
      if (m_pix == NP - 1) begin
        m_hold = 1; new_done = 1; m_load = 0;
      end else m_pix++;
    end
    if (acc) begin
      for (int k = 0; k < 8; k++) m_bits.push_back(d[k]);
      m_bytes++;
      m_load = 1;
    end
    if (was_hold && rel) begin
      m_hold = 0; m_bytes = 0; m_pix = 0;
    end
    m_done = new_done;
    m_err  = (rx && !acc) || (m_err && !clr);
  endfunction

  function automatic logic [AW+4:0] exp_vec();
    logic we = (m_bits.size() > 0);
    return {we, we ? AW'(m_pix) : m_addr, we ? m_bits[0] : m_data, m_done, m_load, m_err};
  endfunction

  function automatic logic [AW+4:0] obs_vec();
    return {ram_we, ram_addr, ram_data, img_done, loading, ovr_err};
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle at negedge.
  task automatic tick(input logic rx, input logic [7:0] d, input logic rel, input logic clr);
    rx_rdy = rx; rx_data = d; img_release = rel; clr_err = clr;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(rx, d, rel, clr);
    @(negedge clk);
    rx_rdy = 1'b0; img_release = 1'b0; clr_err = 1'b0;
    cyc++;
    if (ram_we === 1'b1 && ram_addr < AW'(NP)) wcount[ram_addr]++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) wcount[i] = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1, 8'hFF, 0, 0);
    tick(1, 8'hFF, 0, 0);
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", obs_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [7:0] pat = 8'hA5;
    do_reset();
    tick(1, pat, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({ram_we, ram_addr, ram_data} !== {1'b1, AW'(i), pat[i]}) begin
        errors++;
        $display("FAIL single_byte bit %0d got we=%b addr=%0d data=%b want we=1 addr=%0d data=%b",
                 i, ram_we, ram_addr, ram_data, i, pat[i]);
      end
      tick(0, 8'h00, 0, 0);
    end
    checks++;
    if ({ram_we, loading, ovr_err, img_done} !== 4'b0100) begin
      errors++;
      $display("FAIL single_byte_wait got we=%b loading=%b err=%b done=%b want 0,1,0,0",
               ram_we, loading, ovr_err, img_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1 = 8'($urandom);
    logic [7:0] b2 = 8'($urandom);
    logic [15:0] both = {b2, b1};
    int n = 0, first = -1, bad = 0;
    do_reset();
    tick(1, b1, 0, 0);
    for (int c = 0; c < 22; c++) begin
      if (ram_we === 1'b1) begin
        if (first < 0) first = cyc;
        if (ram_addr !== AW'(n) || ram_data !== both[n] || cyc != first + n) bad++;
        n++;
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
      tick(c == 2, b2, 0, 0);
    end
    checks++;
    if (n != 16 || bad != 0) begin
      errors++;
      $display("FAIL back_to_back_stream got %0d writes %0d out of order want 16 and 0", n, bad);
    end
    checks++;
    if (ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_err got %b want 0", ovr_err);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    tick(1, 8'h11, 0, 0);
    tick(1, 8'h22, 0, 0);
    tick(1, 8'h33, 0, 0);
    checks++;
    if (ovr_err !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b want 1", ovr_err);
    end
    for (int c = 0; c < 20; c++) begin
      tick(0, 8'h00, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL overrun_stream cycle %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
    tick(0, 8'h00, 0, 1);
    checks++;
    if (ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b want 0", ovr_err);
    end
    tick(1, 8'h44, 0, 0);
    tick(1, 8'h55, 0, 0);
    tick(1, 8'h66, 0, 1);
    checks++;
    if (ovr_err !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clr_vs_drop got %b want 1", ovr_err);
    end
  endtask

  // Streams a whole image at the given byte spacing, comparing every cycle.
  task automatic test_full_image(input int gap, input string tag);
    int done_n = 0, done_cyc = -1, last_cyc = -1, bad = 0;
    for (int b = 0; b < NB + 2; b++) begin
      for (int k = 0; k < gap; k++) begin
        tick((k == 0) && (b < NB), 8'($urandom), 0, 0);
        if (ram_we === 1'b1 && ram_addr === AW'(NP - 1)) last_cyc = cyc;
        if (img_done === 1'b1) begin done_n++; done_cyc = cyc; end
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL %s cycle %0d got %h want %h", tag, cyc, obs_vec(), exp_vec());
        end
      end
    end
    for (int i = 0; i < NP; i++) if (wcount[i] != 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_coverage got %0d addresses not written exactly once want 0", tag, bad);
    end
    checks++;
    if (done_n != 1 || done_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL %s_done got %0d pulses at %0d (last write %0d) want 1 pulse one cycle after",
               tag, done_n, done_cyc, last_cyc);
    end
  endtask

  task automatic test_hold();
    tick(1, 8'hFF, 0, 0);
    checks++;
    if ({ram_we, ovr_err, loading} !== 3'b010) begin
      errors++;
      $display("FAIL hold_extra_byte got we=%b err=%b loading=%b want 0,1,0", ram_we, ovr_err, loading);
    end
    tick(0, 8'h00, 1, 1);
    tick(1, 8'h3D, 0, 0);
    checks++;
    if ({ram_we, ram_addr, ram_data, loading} !== {1'b1, AW'(0), 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL hold_release got we=%b addr=%0d data=%b loading=%b want 1,0,1,1",
               ram_we, ram_addr, ram_data, loading);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset();
    while (!(m_bits.size() > 0 && m_pix == 300) && guard < 4000) begin
      tick((guard % 20) == 0, 8'($urandom), 0, 0);
      guard++;
    end
    checks++;
    if (guard >= 4000) begin
      errors++;
      $display("FAIL reset_mid_reach got timeout want addr 300 write");
    end
    rst_n = 1'b0;
    tick(0, 8'h00, 0, 0);
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h want 0", obs_vec());
    end
    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) wcount[i] = 0;
    test_full_image(20, "reset_mid_image");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      tick($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 40) == 0,
           $urandom_range(0, 15) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    do_reset();
    test_full_image(20, "full_image");
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_loader.md
PIXEL_LOADER -- requirements
Module: pixel_loader

Interface
REQ-001 Parameter NUM_PIXELS, default 784, pixels per image; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10, width of the input-RAM address.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 rx_rdy  input  1  one-cycle pulse: rx_data holds a new received byte.
REQ-006 rx_data  input  8  received byte; bit k is pixel (8*byte_index + k).
REQ-007 release  input  1  one-cycle pulse: the consumer has finished reading the image.
REQ-008 clr_err  input  1  clears ovr_err.
REQ-009 ram_we  output  1  write enable to the 1-bit-wide input RAM.
REQ-010 ram_addr  output  ADDR_WIDTH  RAM write address (pixel index).
REQ-011 ram_data  output  1  pixel bit to write.
REQ-012 img_done  output  1  one-cycle pulse: the full image is in RAM (drives the consumer's start).
REQ-013 loading  output  1  high from the first accepted byte until img_done.
REQ-014 ovr_err  output  1  sticky: a byte was dropped.

Function
REQ-015 The block SHALL have states IDLE, UNPACK, WAIT_BYTE and HOLD.
REQ-016 Counters: byte_cnt (0..NUM_PIXELS/8), bit_idx (0..7) and pix_cnt (0..NUM_PIXELS-1).
- Buffers: shift byte cur_byte, plus one pending register pend_byte with a valid flag pend_v.
REQ-017 Byte acceptance: a byte SHALL be accepted only when all of these hold:
- rx_rdy=1;
- byte_cnt < NUM_PIXELS/8;
- the block is in IDLE/WAIT_BYTE, or it is in UNPACK with pend_v=0.
- Each accepted byte SHALL increment byte_cnt by 1.
REQ-018 IDLE/WAIT_BYTE with an accepted byte at cycle N: cur_byte <= rx_data, bit_idx <= 0, state -> UNPACK.
- ram_we SHALL first be high at cycle N+1.
REQ-019 UNPACK: each cycle ram_we=1, ram_addr=pix_cnt, ram_data=cur_byte[bit_idx]; then pix_cnt and bit_idx increment.
- A byte SHALL therefore be written over exactly 8 consecutive cycles, LSB first.
REQ-020 UNPACK with an accepted byte: the byte SHALL be stored in pend_byte and pend_v set; the current write is not disturbed.
REQ-021 End of the byte (bit_idx=7), pixel not last: the next state depends on pend_v.
- pend_v=1: load pend_byte into cur_byte, clear pend_v and stay in UNPACK. Writes SHALL continue with no gap cycle.
- pend_v=0: go to WAIT_BYTE.
REQ-022 End of the byte (bit_idx=7), pixel NUM_PIXELS-1 (the last pixel): img_done SHALL be 1 on the next cycle, and the state -> HOLD.
REQ-023 loading SHALL go low in the same cycle img_done goes high.
REQ-024 ram_we SHALL be 0 in IDLE, WAIT_BYTE and HOLD; ram_addr and ram_data hold their last values there.
REQ-025 HOLD: release=1 SHALL return the block to IDLE next cycle, with byte_cnt, pix_cnt, bit_idx and pend_v cleared.
- release outside HOLD SHALL be ignored.
REQ-026 Dropped byte: rx_rdy=1 that is not accepted (REQ-017) SHALL discard the byte and set ovr_err next cycle.
- This covers an extra byte once byte_cnt is full, a byte in HOLD, and a byte while pend_v=1.
REQ-027 ovr_err SHALL stay set until clr_err=1 or reset.
- If clr_err and a drop occur in the same cycle, ovr_err SHALL be 1.
REQ-028 Counter widths: pix_cnt SHALL never wrap past NUM_PIXELS-1, and byte_cnt SHALL saturate at NUM_PIXELS/8.
REQ-029 rx_rdy in the same cycle as the final write of the last byte SHALL be dropped (byte_cnt is already full).

Reset
REQ-030 While rst_n=0 at a clk edge: state=IDLE, all counters 0, pend_v=0, cur_byte=0, pend_byte=0.
REQ-031 Output reset values: ram_we=0, ram_addr=0, ram_data=0, img_done=0, loading=0, ovr_err=0.
REQ-032 Reset mid-UNPACK SHALL abort the image; the next accepted byte SHALL be written starting at address 0.

Verification
REQ-033 Single byte 0xA5 at cycle N -> ram_we=1 for cycles N+1..N+8, addr 0..7, data 1,0,1,0,0,1,0,1; then WAIT_BYTE with loading=1.
REQ-034 98 bytes, spaced 20 cycles apart -> 784 writes, addr 0..783, each exactly once; img_done=1 for one cycle after addr 783; state HOLD.
REQ-035 Byte 2 arrives 3 cycles after byte 1 -> byte 2 goes to pend_byte; its writes (addr 8..15) directly follow addr 7 with no gap; ovr_err=0.
REQ-036 Bytes 2 and 3 both arrive during byte 1's UNPACK -> byte 3 is dropped and ovr_err=1.
- A clr_err pulse afterwards -> ovr_err=0.
REQ-037 In HOLD: a 99th byte -> no write and ovr_err=1; then release -> IDLE; the next byte is written at addr 0.
REQ-038 rst_n=0 for one cycle during the write of addr 300 -> all outputs at reset values; the following image loads from addr 0 and img_done fires after 98 bytes.
